// File: rtl/mem_wb_lanes.sv
// Multi-lane MEM/WB pipeline register: stall-aware bubble/hold, synchronous flush,
// same-bundle write-after-write resolution and a retired-instruction counter.
module mem_wb_lanes #(
  parameter int unsigned LANES   = 2,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned STALL_W = 6,
  parameter int unsigned STAGE   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [STALL_W-1:0]       stall,
  input  logic                     flush,
  input  logic [LANES-1:0]         mem_valid,
  input  logic [LANES-1:0]         mem_wreg,
  input  logic [LANES*ADDR_W-1:0]  mem_wd,
  input  logic [LANES*DATA_W-1:0]  mem_wdata,
  input  logic                     mem_whilo,
  input  logic [DATA_W-1:0]        mem_hi,
  input  logic [DATA_W-1:0]        mem_lo,
  input  logic                     cnt_clr,
  output logic [LANES-1:0]         wb_valid,
  output logic [LANES-1:0]         wb_wreg,
  output logic [LANES*ADDR_W-1:0]  wb_wd,
  output logic [LANES*DATA_W-1:0]  wb_wdata,
  output logic                     wb_whilo,
  output logic [DATA_W-1:0]        wb_hi,
  output logic [DATA_W-1:0]        wb_lo,
  output logic [31:0]              retire_cnt
);

  logic [LANES-1:0]        r_valid;
  logic [LANES-1:0]        r_wreg;
  logic [LANES*ADDR_W-1:0] r_wd;
  logic [LANES*DATA_W-1:0] r_wdata;
  logic                    r_whilo;
  logic [DATA_W-1:0]       r_hi;
  logic [DATA_W-1:0]       r_lo;
  logic [31:0]             r_retire_cnt;

  logic [LANES-1:0] w_qual;
  logic [LANES-1:0] w_wreg;
  logic [31:0]      w_pop;
  logic             w_load;
  logic             w_bubble;

  assign w_load   = ~stall[STAGE];
  assign w_bubble = flush | (stall[STAGE] & ~stall[STAGE+1]);

  // A lane's write is dropped when any higher lane also writes the same register.
  always_comb begin
    w_qual = '0;
    w_wreg = '0;
    w_pop  = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      w_qual[i] = mem_wreg[i] & mem_valid[i] & (mem_wd[i*ADDR_W +: ADDR_W] != '0);
      w_pop     = w_pop + 32'(mem_valid[i]);
    end
    for (int unsigned i = 0; i < LANES; i++) begin
      w_wreg[i] = w_qual[i];
      for (int unsigned j = i + 1; j < LANES; j++) begin
        if (w_qual[j] && (mem_wd[j*ADDR_W +: ADDR_W] == mem_wd[i*ADDR_W +: ADDR_W])) begin
          w_wreg[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid      <= '0;
      r_wreg       <= '0;
      r_wd         <= '0;
      r_wdata      <= '0;
      r_whilo      <= 1'b0;
      r_hi         <= '0;
      r_lo         <= '0;
      r_retire_cnt <= '0;
    end else begin
      if (w_bubble) begin
        r_valid <= '0;
        r_wreg  <= '0;
        r_wd    <= '0;
        r_wdata <= '0;
        r_whilo <= 1'b0;
        r_hi    <= '0;
        r_lo    <= '0;
      end else if (w_load) begin
        r_valid <= mem_valid;
        r_wreg  <= w_wreg;
        r_wd    <= mem_wd;
        r_wdata <= mem_wdata;
        r_whilo <= mem_whilo & (|mem_valid);
        r_hi    <= mem_hi;
        r_lo    <= mem_lo;
      end
      if (cnt_clr) begin
        r_retire_cnt <= '0;
      end else if (w_load && !flush) begin
        r_retire_cnt <= r_retire_cnt + w_pop;
      end
    end
  end

  assign wb_valid   = r_valid;
  assign wb_wreg    = r_wreg;
  assign wb_wd      = r_wd;
  assign wb_wdata   = r_wdata;
  assign wb_whilo   = r_whilo;
  assign wb_hi      = r_hi;
  assign wb_lo      = r_lo;
  assign retire_cnt = r_retire_cnt;

endmodule

// File: tb/tb_mem_wb_lanes.sv
// Scoreboard bench for mem_wb_lanes with LANES=2: expected write-back bundles are queued
// as stimulus is applied and compared one cycle later.
module tb_mem_wb_lanes;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [1:0]  mem_valid;
  logic [1:0]  mem_wreg;
  logic [9:0]  mem_wd;
  logic [63:0] mem_wdata;
  logic        mem_whilo;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic        cnt_clr;
  logic [1:0]  wb_valid;
  logic [1:0]  wb_wreg;
  logic [9:0]  wb_wd;
  logic [63:0] wb_wdata;
  logic        wb_whilo;
  logic [31:0] wb_hi;
  logic [31:0] wb_lo;
  logic [31:0] retire_cnt;

  typedef struct packed {
    logic [1:0]  v;
    logic [1:0]  we;
    logic [9:0]  wd;
    logic [63:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] cnt;
  } out_t;

  out_t obs;
  out_t e;
  out_t sb[$];
  int   n_cmp;
  int   n_bad;
  logic [31:0] exp_cnt;

  assign obs = {wb_valid, wb_wreg, wb_wd, wb_wdata, wb_whilo, wb_hi, wb_lo, retire_cnt};

  mem_wb_lanes #(
    .LANES  (2),
    .DATA_W (32),
    .ADDR_W (5),
    .STALL_W(6),
    .STAGE  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .flush     (flush),
    .mem_valid (mem_valid),
    .mem_wreg  (mem_wreg),
    .mem_wd    (mem_wd),
    .mem_wdata (mem_wdata),
    .mem_whilo (mem_whilo),
    .mem_hi    (mem_hi),
    .mem_lo    (mem_lo),
    .cnt_clr   (cnt_clr),
    .wb_valid  (wb_valid),
    .wb_wreg   (wb_wreg),
    .wb_wd     (wb_wd),
    .wb_wdata  (wb_wdata),
    .wb_whilo  (wb_whilo),
    .wb_hi     (wb_hi),
    .wb_lo     (wb_lo),
    .retire_cnt(retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, bench did not finish");
    $fatal(1);
  end

  function automatic out_t mk(input logic [1:0] v, input logic [1:0] we, input logic [9:0] wd,
                              input logic [63:0] wdata, input logic whilo, input logic [31:0] hi,
                              input logic [31:0] lo, input logic [31:0] cnt);
    out_t o;
    o = {v, we, wd, wdata, whilo, hi, lo, cnt};
    return o;
  endfunction

  task automatic drive(input logic [1:0] v, input logic [1:0] we, input logic [9:0] wd,
                       input logic [63:0] wdata, input logic whilo, input logic [31:0] hi,
                       input logic [31:0] lo);
    mem_valid = v;
    mem_wreg  = we;
    mem_wd    = wd;
    mem_wdata = wdata;
    mem_whilo = whilo;
    mem_hi    = hi;
    mem_lo    = lo;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = '0; flush = 1'b0; cnt_clr = 1'b0;
    drive(2'b00, 2'b00, '0, '0, 1'b0, '0, '0);
    #2;
    sb.push_back(mk('0, '0, '0, '0, 1'b0, '0, '0, '0));
    e = sb.pop_front(); n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL reset_initial: got %h want %h", obs, e); end
    @(negedge clk);
    rst = 1'b0;
    drive(2'b01, 2'b01, {5'd0, 5'd3}, {32'h0, 32'h1234}, 1'b0, '0, '0);
    sb.push_back(mk(2'b01, 2'b01, {5'd0, 5'd3}, {32'h0, 32'h1234}, 1'b0, '0, '0, 32'd1));
    tick();
    e = sb.pop_front(); n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL reset_preload: got %h want %h", obs, e); end
    // Asynchronous reset between edges must clear everything immediately.
    rst = 1'b1;
    sb.push_back(mk('0, '0, '0, '0, 1'b0, '0, '0, '0));
    #1;
    e = sb.pop_front(); n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL reset_async: got %h want %h", obs, e); end
    drive(2'b00, 2'b00, '0, '0, 1'b0, '0, '0);
    #1;
    rst = 1'b0;
    exp_cnt = '0;
  endtask

  task automatic test_load();
    drive(2'b11, 2'b11, {5'd7, 5'd5}, {32'hB, 32'hA}, 1'b1, 32'h1, 32'h2);
    exp_cnt = exp_cnt + 2;
    sb.push_back(mk(2'b11, 2'b11, {5'd7, 5'd5}, {32'hB, 32'hA}, 1'b1, 32'h1, 32'h2, exp_cnt));
    tick();
    e = sb.pop_front(); n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL plain_load: got %h want %h", obs, e); end
  endtask

  task automatic test_waw();
    drive(2'b11, 2'b11, {5'd9, 5'd9}, {32'h22, 32'h11}, 1'b0, 32'h5, 32'h6);
    exp_cnt = exp_cnt + 2;
    sb.push_back(mk(2'b11, 2'b10, {5'd9, 5'd9}, {32'h22, 32'h11}, 1'b0, 32'h5, 32'h6, exp_cnt));
    tick();
    e = sb.pop_front(); n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL waw_same_dest: got %h want %h", obs, e); end

    drive(2'b11, 2'b11, {5'd0, 5'd4}, {32'h44, 32'h33}, 1'b0, '0, '0);
    exp_cnt = exp_cnt + 2;
    sb.push_back(mk(2'b11, 2'b01, {5'd0, 5'd4}, {32'h44, 32'h33}, 1'b0, '0, '0, exp_cnt));
    tick();
    e = sb.pop_front(); n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL waw_zero_reg: got %h want %h", obs, e); end

    // An invalid upper lane must not shadow lane 0.
    drive(2'b01, 2'b11, {5'd9, 5'd9}, {32'h66, 32'h55}, 1'b1, 32'h7, 32'h8);
    exp_cnt = exp_cnt + 1;
    sb.push_back(mk(2'b01, 2'b01, {5'd9, 5'd9}, {32'h66, 32'h55}, 1'b1, 32'h7, 32'h8, exp_cnt));
    tick();
    e = sb.pop_front(); n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL waw_invalid_hi: got %h want %h", obs, e); end

    drive(2'b00, 2'b11, {5'd3, 5'd2}, {32'h88, 32'h77}, 1'b1, 32'h9, 32'hA);
    sb.push_back(mk(2'b00, 2'b00, {5'd3, 5'd2}, {32'h88, 32'h77}, 1'b0, 32'h9, 32'hA, exp_cnt));
    tick();
    e = sb.pop_front(); n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL whilo_no_valid: got %h want %h", obs, e); end
  endtask

  task automatic test_stall();
    out_t a;
    drive(2'b11, 2'b11, {5'd3, 5'd2}, {32'hA2, 32'hA1}, 1'b1, 32'hAA, 32'hBB);
    exp_cnt = exp_cnt + 2;
    a = mk(2'b11, 2'b11, {5'd3, 5'd2}, {32'hA2, 32'hA1}, 1'b1, 32'hAA, 32'hBB, exp_cnt);
    sb.push_back(a);
    tick();
    e = sb.pop_front(); n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL stall_pre_load: got %h want %h", obs, e); end

    stall = 6'b011111;
    sb.push_back(mk('0, '0, '0, '0, 1'b0, '0, '0, exp_cnt));
    tick();
    e = sb.pop_front(); n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL stall_bubble: got %h want %h", obs, e); end

    stall = 6'b000000;
    exp_cnt = exp_cnt + 2;
    a.cnt = exp_cnt;
    sb.push_back(a);
    tick();
    e = sb.pop_front(); n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL stall_reload: got %h want %h", obs, e); end

    stall = 6'b111111;
    drive(2'b11, 2'b11, {5'd12, 5'd11}, {32'hB2, 32'hB1}, 1'b0, 32'hCC, 32'hDD);
    for (int k = 0; k < 3; k++) begin
      sb.push_back(a);
      tick();
      e = sb.pop_front(); n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL stall_hold%0d: got %h want %h", k, obs, e); end
    end

    // stall[STAGE+1] alone must not stop this stage.
    stall = 6'b100000;
    exp_cnt = exp_cnt + 2;
    sb.push_back(mk(2'b11, 2'b11, {5'd12, 5'd11}, {32'hB2, 32'hB1}, 1'b0, 32'hCC, 32'hDD,
                    exp_cnt));
    tick();
    e = sb.pop_front(); n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL stall_release: got %h want %h", obs, e); end
    stall = '0;
  endtask

  task automatic test_flush();
    flush = 1'b1;
    sb.push_back(mk('0, '0, '0, '0, 1'b0, '0, '0, exp_cnt));
    tick();
    e = sb.pop_front(); n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL flush_load: got %h want %h", obs, e); end

    drive(2'b11, 2'b11, {5'd1, 5'd2}, {32'h1, 32'h2}, 1'b1, 32'h3, 32'h4);
    flush = 1'b0;
    exp_cnt = exp_cnt + 2;
    sb.push_back(mk(2'b11, 2'b11, {5'd1, 5'd2}, {32'h1, 32'h2}, 1'b1, 32'h3, 32'h4, exp_cnt));
    tick();
    e = sb.pop_front(); n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL flush_refill: got %h want %h", obs, e); end

    flush = 1'b1;
    stall = 6'b111111;
    sb.push_back(mk('0, '0, '0, '0, 1'b0, '0, '0, exp_cnt));
    tick();
    e = sb.pop_front(); n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL flush_over_hold: got %h want %h", obs, e); end
    flush = 1'b0;
    stall = '0;
  endtask

  task automatic test_counter();
    out_t c;
    force dut.r_retire_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_retire_cnt;
    drive(2'b11, 2'b01, {5'd6, 5'd6}, {32'hC2, 32'hC1}, 1'b0, 32'hC3, 32'hC4);
    exp_cnt = 32'd1;
    c = mk(2'b11, 2'b01, {5'd6, 5'd6}, {32'hC2, 32'hC1}, 1'b0, 32'hC3, 32'hC4, exp_cnt);
    sb.push_back(c);
    tick();
    e = sb.pop_front(); n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL cnt_wrap: got %h want %h", obs, e); end

    cnt_clr = 1'b1;
    exp_cnt = '0;
    c.cnt = exp_cnt;
    sb.push_back(c);
    tick();
    e = sb.pop_front(); n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL cnt_clr_load: got %h want %h", obs, e); end

    cnt_clr = 1'b0;
    exp_cnt = 32'd2;
    c.cnt = exp_cnt;
    sb.push_back(c);
    tick();
    e = sb.pop_front(); n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL cnt_after_clr: got %h want %h", obs, e); end

    stall = 6'b111111;
    cnt_clr = 1'b1;
    exp_cnt = '0;
    c.cnt = exp_cnt;
    sb.push_back(c);
    tick();
    e = sb.pop_front(); n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL cnt_clr_hold: got %h want %h", obs, e); end
    cnt_clr = 1'b0;
    stall = '0;
  endtask

  task automatic test_random();
    out_t prev;
    out_t nx;
    logic [31:0] seen;
    logic [4:0] a;
    logic ld;
    prev = mk(mem_valid, '0, mem_wd, mem_wdata, 1'b0, mem_hi, mem_lo, exp_cnt);
    prev = obs;
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 3))
        0: stall = 6'b000000;
        1: stall = 6'b011111;
        2: stall = 6'b111111;
        default: stall = 6'b100111;
      endcase
      flush   = ($urandom_range(0, 7) == 0);
      cnt_clr = ($urandom_range(0, 9) == 0);
      drive(2'($urandom), 2'($urandom), {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))},
            {$urandom, $urandom}, 1'($urandom), $urandom, $urandom);
      ld = !stall[4];
      if (flush || (stall[4] && !stall[5])) begin
        nx = mk('0, '0, '0, '0, 1'b0, '0, '0, prev.cnt);
      end else if (ld) begin
        nx = mk(mem_valid, '0, mem_wd, mem_wdata, mem_whilo && (mem_valid != 0), mem_hi, mem_lo,
                prev.cnt);
        seen = '0;
        for (int i = 1; i >= 0; i--) begin
          a = mem_wd[i*5 +: 5];
          if (mem_valid[i] && mem_wreg[i] && a != 0) begin
            nx.we[i] = !seen[a];
            seen[a] = 1'b1;
          end
        end
      end else begin
        nx = prev;
      end
      if (cnt_clr) nx.cnt = '0;
      else if (ld && !flush) nx.cnt = prev.cnt + 32'(mem_valid[0]) + 32'(mem_valid[1]);
      sb.push_back(nx);
      tick();
      e = sb.pop_front(); n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL random%0d: got %h want %h", k, obs, e); end
      prev = nx;
    end
    stall = '0; flush = 1'b0; cnt_clr = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    exp_cnt = '0;
    test_reset();
    test_load();
    test_waw();
    test_stall();
    test_flush();
    test_counter();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
